mbl_stream_arb: RTL and testbench

Packet-level round-robin arbiter that merges NUM_IN sof/eof/valid/ready streams onto one output stream. A grant is held from the accepted sof beat through the accepted eof beat, so packets are never interleaved. It sits between several producers wired to the stream interface's master modports and a single consumer on a slave modport, for example a shared egress buffer.

---
 rtl/mbl_stream_pkg.sv | 39 +++
 rtl/mbl_rr_picker.sv | 51 +++++
 rtl/mbl_stream_arb.sv | 136 +++++++++++++
 tb/tb_mbl_stream_arb.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbl_stream_pkg.sv
// Shared types and helpers for the packet round-robin stream arbiter.
package mbl_stream_pkg;

   // Arbiter FSM: waiting for a start-of-packet, or forwarding one packet.
   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   localparam int unsigned RR_MAX_IN = 16;

   // Returns the first set bit of req at or after ptr, wrapping modulo num.
   // Returns 0 when req is empty; callers qualify with |req.
   function automatic logic [3:0] rr_pick(input logic [15:0] req,
                                          input logic [3:0]  ptr,
                                          input logic [4:0]  num = 5'd16);
      logic [3:0] win;
      logic       found;
      logic [4:0] idx;
      win   = 4'd0;
      found = 1'b0;
      for (int k = 0; k < RR_MAX_IN; k++) begin
         idx = 5'(ptr) + 5'(k);
         if (idx >= num) begin
            idx = idx - num;
         end else begin
            idx = idx;
         end
         if (!found && (5'(k) < num) && req[idx[3:0]]) begin
            win   = idx[3:0];
            found = 1'b1;
         end else begin
            found = found;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/mbl_rr_picker.sv
// Combinational round-robin picker: rotate by pointer, priority encode, unrotate.
module mbl_rr_picker
   import mbl_stream_pkg::*;
#(
   parameter int NUM_IN = 4
) (
   input  logic [NUM_IN-1:0]         i_req,
   input  logic [$clog2(NUM_IN)-1:0] i_ptr,
   output logic                      o_any,
   output logic [$clog2(NUM_IN)-1:0] o_winner
);

   localparam int PW = $clog2(NUM_IN);

   logic [PW:0]        w_idx;
   logic [NUM_IN-1:0]  w_rot;
   logic [3:0]         w_off;
   logic [PW:0]        w_sum;

   // Rotate the request vector so that bit 0 is the input at the pointer.
   always_comb begin
      w_rot = '0;
      w_idx = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         w_idx = (PW+1)'(k) + (PW+1)'(i_ptr);
         if (w_idx >= (PW+1)'(NUM_IN)) begin
            w_idx = w_idx - (PW+1)'(NUM_IN);
         end else begin
            w_idx = w_idx;
         end
         w_rot[k] = i_req[w_idx[PW-1:0]];
      end
   end

   // Lowest set bit of the rotated vector is the offset from the pointer.
   assign w_off = rr_pick(16'(w_rot), 4'd0, 5'(NUM_IN));

   // Unrotate: add the pointer back and wrap into 0..NUM_IN-1.
   always_comb begin
      w_sum = (PW+1)'(i_ptr) + (PW+1)'(w_off);
      if (w_sum >= (PW+1)'(NUM_IN)) begin
         w_sum = w_sum - (PW+1)'(NUM_IN);
      end else begin
         w_sum = w_sum;
      end
   end

   assign o_winner = w_sum[PW-1:0];
   assign o_any    = |i_req;

endmodule

// File: rtl/mbl_stream_arb.sv
// Packet-level round-robin arbiter merging NUM_IN sof/eof streams onto one.
module mbl_stream_arb
   import mbl_stream_pkg::*;
#(
   parameter int NUM_IN = 4,
   parameter int DW     = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_IN*DW-1:0]      in_data,
   input  logic [NUM_IN-1:0]         in_sof,
   input  logic [NUM_IN-1:0]         in_eof,
   input  logic [NUM_IN-1:0]         in_valid,
   output logic [NUM_IN-1:0]         in_ready,
   output logic [DW-1:0]             out_data,
   output logic                      out_sof,
   output logic                      out_eof,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [$clog2(NUM_IN)-1:0] grant_id,
   output logic                      busy,
   output logic [NUM_IN-1:0]         proto_err
);

   localparam int PW = $clog2(NUM_IN);

   arb_state_e        r_state;
   arb_state_e        w_state_nxt;
   logic [PW-1:0]     r_grant;
   logic [PW-1:0]     w_grant_nxt;
   logic [PW-1:0]     r_rr_ptr;
   logic [PW-1:0]     w_rr_ptr_nxt;
   logic [NUM_IN-1:0] r_proto_err;
   logic [NUM_IN-1:0] w_proto_err_nxt;
   logic [NUM_IN-1:0] w_req;
   logic [NUM_IN-1:0] w_drop;
   logic [NUM_IN-1:0] w_ready;
   logic              w_any;
   logic [PW-1:0]     w_winner;
   logic              w_busy;

   assign w_busy = (r_state == ARB_BUSY);
   assign w_req  = in_valid & in_sof;

   mbl_rr_picker #(.NUM_IN(NUM_IN)) u_picker (
      .i_req    (w_req),
      .i_ptr    (r_rr_ptr),
      .o_any    (w_any),
      .o_winner (w_winner)
   );

   // Beats without sof on any input that does not own the output are dropped.
   always_comb begin
      w_drop = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (w_busy && (r_grant == PW'(i))) begin
            w_drop[i] = 1'b0;
         end else begin
            w_drop[i] = in_valid[i] & ~in_sof[i];
         end
      end
   end

   // Zero-latency pass-through of the granted input while a packet is in flight.
   always_comb begin
      out_data  = '0;
      out_sof   = 1'b0;
      out_eof   = 1'b0;
      out_valid = 1'b0;
      w_ready   = w_drop;
      if (w_busy) begin
         out_data         = in_data[int'(r_grant)*DW +: DW];
         out_sof          = in_sof[r_grant];
         out_eof          = in_eof[r_grant];
         out_valid        = in_valid[r_grant];
         w_ready[r_grant] = out_ready;
      end else begin
         out_valid = 1'b0;
      end
   end

   // in_ready is forced low while reset is asserted, even for dropped beats.
   assign in_ready  = w_ready & {NUM_IN{rst_n}};
   assign grant_id  = r_grant;
   assign busy      = w_busy;
   assign proto_err = r_proto_err;

   // Next-state: grant in IDLE, release on the transferred eof beat.
   always_comb begin
      w_state_nxt     = r_state;
      w_grant_nxt     = r_grant;
      w_rr_ptr_nxt    = r_rr_ptr;
      w_proto_err_nxt = r_proto_err | w_drop;
      case (r_state)
         ARB_IDLE: begin
            if (w_any) begin
               w_state_nxt = ARB_BUSY;
               w_grant_nxt = w_winner;
            end else begin
               w_state_nxt = ARB_IDLE;
            end
         end
         ARB_BUSY: begin
            if (in_valid[r_grant] && out_ready && in_eof[r_grant]) begin
               w_state_nxt = ARB_IDLE;
               if (r_grant == PW'(NUM_IN - 1)) begin
                  w_rr_ptr_nxt = '0;
               end else begin
                  w_rr_ptr_nxt = r_grant + PW'(1);
               end
            end else begin
               w_state_nxt = ARB_BUSY;
            end
         end
         default: begin
            w_state_nxt = ARB_IDLE;
         end
      endcase
   end

   // State, grant, pointer and sticky error registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ARB_IDLE;
         r_grant     <= '0;
         r_rr_ptr    <= '0;
         r_proto_err <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_grant     <= w_grant_nxt;
         r_rr_ptr    <= w_rr_ptr_nxt;
         r_proto_err <= w_proto_err_nxt;
      end
   end

endmodule

// File: tb/tb_mbl_stream_arb.sv
// Randomized scoreboard bench for mbl_stream_arb with a packet-level reference model.
module tb_mbl_stream_arb;

   localparam int N  = 4;
   localparam int DW = 32;

   typedef struct packed {
      logic          err;
      logic          sof;
      logic          eof;
      logic [DW-1:0] data;
   } beat_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N*DW-1:0] in_data;
   logic [N-1:0]    in_sof;
   logic [N-1:0]    in_eof;
   logic [N-1:0]    in_valid;
   logic [N-1:0]    in_ready;
   logic [DW-1:0]   out_data;
   logic            out_sof;
   logic            out_eof;
   logic            out_valid;
   logic            out_ready;
   logic [1:0]      grant_id;
   logic            busy;
   logic [N-1:0]    proto_err;

   beat_t drv_q [N][$];
   beat_t exp_q [N][$];
   int    grant_log [$];

   int n_chk = 0;
   int n_err = 0;
   int beats_seen = 0;

   int           m_busy;
   int           m_own;
   int           m_ptr;
   logic [N-1:0] m_perr;
   logic [N-1:0] acc;
   logic [N-1:0] mon_rdy;
   beat_t        mon_e;
   int           mon_found;

   always #5 clk = ~clk;

   mbl_stream_arb #(.NUM_IN(N), .DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_sof    (in_sof),
      .in_eof    (in_eof),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_sof   (out_sof),
      .out_eof   (out_eof),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .grant_id  (grant_id),
      .busy      (busy),
      .proto_err (proto_err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor + reference model: owner is the first sof requester from the pointer.
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         m_busy = 0;
         m_own  = 0;
         m_ptr  = 0;
         m_perr = '0;
         acc    = '0;
         for (int i = 0; i < N; i++) exp_q[i].delete();
      end else begin
         acc = in_valid & in_ready;
         chk("busy", 64'(busy), 64'(m_busy));
         chk("proto_err", 64'(proto_err), 64'(m_perr));
         mon_rdy = '0;
         for (int i = 0; i < N; i++) begin
            if (in_valid[i] && !in_sof[i] && !(m_busy != 0 && m_own == i)) begin
               mon_rdy[i] = 1'b1;
               m_perr[i]  = 1'b1;
            end
         end
         if (m_busy != 0) begin
            chk("grant_id", 64'(grant_id), 64'(m_own));
            chk("out_valid", 64'(out_valid), 64'(in_valid[m_own]));
            mon_rdy[m_own] = out_ready;
            if (in_valid[m_own] && out_ready) begin
               if (exp_q[m_own].size() == 0) begin
                  n_chk++;
                  n_err++;
                  $display("FAIL unexpected_beat: got beat from input %0d expected none", m_own);
               end else begin
                  mon_e = exp_q[m_own].pop_front();
                  chk("out_data", 64'(out_data), 64'(mon_e.data));
                  chk("out_sof", 64'(out_sof), 64'(mon_e.sof));
                  chk("out_eof", 64'(out_eof), 64'(mon_e.eof));
                  beats_seen++;
                  if (mon_e.eof) begin
                     m_busy = 0;
                     m_ptr  = (m_own + 1) % N;
                  end
               end
            end
         end else begin
            chk("out_valid_idle", 64'(out_valid), 64'd0);
            mon_found = 0;
            for (int k = 0; k < N; k++) begin
               if (mon_found == 0 && in_valid[(m_ptr + k) % N] && in_sof[(m_ptr + k) % N]) begin
                  mon_found = 1;
                  m_own     = (m_ptr + k) % N;
                  m_busy    = 1;
                  grant_log.push_back(m_own);
               end
            end
         end
         chk("in_ready", 64'(in_ready), 64'(mon_rdy));
      end
   end

   task automatic add_beat(input int i, input logic err, input logic sof, input logic eof,
                           input logic [DW-1:0] data);
      beat_t b;
      b.err  = err;
      b.sof  = sof;
      b.eof  = eof;
      b.data = data;
      drv_q[i].push_back(b);
      if (!err) exp_q[i].push_back(b);
   endtask

   task automatic add_pkt(input int i, input int len);
      for (int b = 0; b < len; b++) add_beat(i, 1'b0, b == 0, b == len - 1, $urandom);
   endtask

   // One cycle of drive: retire accepted beats, present the next ones.
   task automatic step(input int rdy_pct, input int gap_pct);
      beat_t b;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (acc[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
      end
      acc = '0;
      for (int i = 0; i < N; i++) begin
         if (drv_q[i].size() > 0 && $urandom_range(99) >= gap_pct) begin
            b = drv_q[i][0];
            in_valid[i]         = 1'b1;
            in_sof[i]           = b.sof;
            in_eof[i]           = b.eof;
            in_data[i*DW +: DW] = b.data;
         end else begin
            in_valid[i] = 1'b0;
            in_sof[i]   = 1'($urandom);
            in_eof[i]   = 1'($urandom);
         end
      end
      out_ready = ($urandom_range(99) < rdy_pct);
   endtask

   function automatic int pending();
      int p;
      p = m_busy;
      for (int i = 0; i < N; i++) p += drv_q[i].size();
      return p;
   endfunction

   task automatic run(input int rdy_pct, input int gap_pct, input int budget);
      for (int c = 0; c < budget && pending() != 0; c++) step(rdy_pct, gap_pct);
      step(100, 0);
      step(100, 0);
      chk("drain", 64'(pending()), 64'd0);
   endtask

   initial begin
      int b0;
      int left;
      // Reset with every input valid: all outputs at reset values.
      rst_n     = 1'b0;
      in_valid  = 4'b1111;
      in_sof    = 4'b0101;
      in_eof    = 4'b0011;
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      out_ready = 1'b1;
      acc       = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_sof", 64'(out_sof), 64'd0);
      chk("rst_out_eof", 64'(out_eof), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_grant", 64'(grant_id), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_proto_err", 64'(proto_err), 64'd0);
      in_valid = '0;
      @(posedge clk);
      #3;
      rst_n = 1'b1;

      // Contention: four simultaneous 3-beat packets, order 0,1,2,3.
      grant_log.delete();
      for (int i = 0; i < N; i++) add_pkt(i, 3);
      run(100, 0, 200);
      chk("contention_grants", 64'(grant_log.size()), 64'd4);
      for (int k = 0; k < grant_log.size() && k < 4; k++) chk("contention_order", 64'(grant_log[k]), 64'(k));

      // Backpressure: 4-beat packet from input 1 with random out_ready.
      add_pkt(1, 4);
      run(50, 0, 300);

      // Single-beat packet, then a sof-less beat on input 0 while idle.
      add_beat(3, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
      run(100, 0, 50);
      add_beat(0, 1'b1, 1'b0, 1'b0, $urandom);
      run(100, 0, 50);
      chk("err_proto_err", 64'(proto_err), 64'd1);

      // Reset during beat 3 of a 5-beat packet.
      add_pkt(1, 5);
      b0 = beats_seen;
      for (int c = 0; c < 100 && beats_seen - b0 < 2; c++) step(100, 0);
      chk("midrst_reached", 64'(beats_seen - b0 >= 2), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd0);
      chk("midrst_out_data", 64'(out_data), 64'd0);
      chk("midrst_proto_err", 64'(proto_err), 64'd0);
      for (int i = 0; i < N; i++) drv_q[i].delete();
      in_valid = '0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      grant_log.delete();
      add_pkt(2, 3);
      run(100, 0, 100);
      chk("postrst_grant", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'd2);

      // Randomized traffic with occasional protocol errors.
      for (int it = 0; it < 30; it++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(1) == 1) begin
               if ($urandom_range(9) == 0) add_beat(i, 1'b1, 1'b0, 1'b0, $urandom);
               add_pkt(i, $urandom_range(4, 1));
            end
         end
         run($urandom_range(100, 40), $urandom_range(30), 2000);
      end

      left = 0;
      for (int i = 0; i < N; i++) left += exp_q[i].size();
      chk("exp_left", 64'(left), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
